stash_nav: RTL and testbench

//  Parametrised successor to the lab-1 sample stash: a circular history of the last DEPTH

---
 rtl/stash_nav_if.sv | 30 +++
 rtl/stash_nav.sv | 101 ++++++++++
 tb/tb_stash_nav.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/stash_nav_if.sv
// Purpose: bundles the stash_nav sample, strobe and display signals.
// Latency: none; this is wiring only.
// Backpressure: none; every strobe is a one-cycle pulse and is always accepted.
interface stash_nav_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 5
);
   logic [WIDTH-1:0]           sample_in;
   logic                       sample_in_valid;
   logic                       next_sample;
   logic                       prev_sample;
   logic                       clear;
   logic [WIDTH-1:0]           sample_out;
   logic [$clog2(DEPTH)-1:0]   view_index;
   logic [$clog2(DEPTH+1)-1:0] count;
   logic                       full;
   logic                       showing_latest;

   // Producer side: sampling logic plus navigation buttons.
   modport master (
      output sample_in, sample_in_valid, next_sample, prev_sample, clear,
      input  sample_out, view_index, count, full, showing_latest
   );

   // Stash side.
   modport slave (
      input  sample_in, sample_in_valid, next_sample, prev_sample, clear,
      output sample_out, view_index, count, full, showing_latest
   );
endinterface

// File: rtl/stash_nav.sv
// Purpose: circular history of the last DEPTH samples; can be browsed oldest-to-newest, and a new sample is held on display.
// Latency: each event appears on the outputs one cycle after its clock edge (outputs decode registered state).
// Backpressure: none; writes always land and overwrite the oldest entry when full.
module stash_nav #(
   parameter int WIDTH       = 8,
   parameter int DEPTH       = 5,
   parameter int HOLD_CYCLES = 50_000_000
) (
   input logic        clk,
   input logic        reset,
   stash_nav_if.slave bus
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
   localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
   localparam logic [IW:0]   WRAP = (IW + 1)'(DEPTH);
   localparam logic [CW-1:0] CAP  = CW'(DEPTH);
   localparam logic [HW-1:0] HOLD = HW'(HOLD_CYCLES);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [IW-1:0]    wr_ptr;
   logic [IW-1:0]    oldest_ptr;
   logic [IW-1:0]    read_idx;
   logic [CW-1:0]    occ;
   logic [HW-1:0]    hold_cnt;

   logic [IW-1:0]    last_idx;
   logic             nav;
   logic [IW-1:0]    newest_ptr;
   logic [IW:0]      rd_sum;
   logic [IW-1:0]    rd_ptr;

   // Compare-and-wrap increment, so DEPTH need not be a power of two.
   function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] p);
      return (p == LAST) ? '0 : p + IW'(1);
   endfunction

   // Derive the navigation decision and the physical addresses from the logical state.
   always_comb begin
      last_idx   = IW'(occ - CW'(1));
      nav        = (occ != '0) && (bus.next_sample ^ bus.prev_sample);
      newest_ptr = (wr_ptr == '0) ? LAST : wr_ptr - IW'(1);
      rd_sum     = {1'b0, oldest_ptr} + {1'b0, read_idx};
      rd_ptr     = (rd_sum >= WRAP) ? IW'(rd_sum - WRAP) : rd_sum[IW-1:0];
   end

   // History, pointers, browse index and hold timer. Reset beats clear, and clear beats write and navigation.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr     <= '0;
         oldest_ptr <= '0;
         read_idx   <= '0;
         occ        <= '0;
         hold_cnt   <= '0;
      end else if (bus.clear) begin
         wr_ptr     <= '0;
         oldest_ptr <= '0;
         read_idx   <= '0;
         occ        <= '0;
         hold_cnt   <= '0;
      end else begin
         // Navigation wraps over the pre-write occupancy.
         if (nav) begin
            if (bus.next_sample)
               read_idx <= (read_idx == last_idx) ? '0 : read_idx + IW'(1);
            else
               read_idx <= (read_idx == '0) ? last_idx : read_idx - IW'(1);
         end
         if (bus.sample_in_valid) begin
            mem[wr_ptr] <= bus.sample_in;
            wr_ptr      <= wrap_inc(wr_ptr);
            if (occ == CAP)
               oldest_ptr <= wrap_inc(oldest_ptr);
            else
               occ <= occ + CW'(1);
            hold_cnt <= HOLD;
         end else if (nav) begin
            hold_cnt <= '0;
         end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HW'(1);
         end
      end
   end

   // While the hold timer runs, show the newest entry; otherwise show the browsed entry.
   always_comb begin
      bus.showing_latest = (hold_cnt != '0);
      bus.full           = (occ == CAP);
      bus.count          = occ;
      if (bus.showing_latest) begin
         bus.view_index = last_idx;
         bus.sample_out = mem[newest_ptr];
      end else begin
         bus.view_index = read_idx;
         bus.sample_out = mem[rd_ptr];
      end
      if (occ == '0) bus.sample_out = '0;
   end
endmodule

// File: tb/tb_stash_nav.sv
// Purpose: checks stash_nav against a queue-based history model, using directed scenarios and then random traffic.
// Latency: compares outputs 1 time unit after each rising edge.
// Backpressure: not applicable; the stimulus is strobes only.
module tb_stash_nav;
   localparam int W = 8;
   localparam int D = 4;
   localparam int H = 3;

   logic clk = 1'b0;
   logic reset;
   int   n_vec = 0;
   int   n_bad = 0;

   // Reference state: history kept oldest-first, plus a logical view index and hold timer.
   logic [W-1:0] hist [$];
   int           ridx = 0;
   int           hold = 0;

   stash_nav_if #(.WIDTH(W), .DEPTH(D)) bus ();

   stash_nav #(.WIDTH(W), .DEPTH(D), .HOLD_CYCLES(H)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_step(input bit rst, input bit clr, input bit wr,
                             input bit nx, input bit pv, input logic [W-1:0] din);
      int  n;
      bit  mv;
      if (rst || clr) begin
         hist.delete();
         ridx = 0;
         hold = 0;
      end else begin
         n  = hist.size();
         mv = (n != 0) && (nx != pv);
         if (mv) begin
            if (nx) ridx = (ridx == n - 1) ? 0 : ridx + 1;
            else    ridx = (ridx == 0) ? n - 1 : ridx - 1;
         end
         if (wr) begin
            hist.push_back(din);
            if (hist.size() > D) void'(hist.pop_front());
            hold = H;
         end else if (mv) begin
            hold = 0;
         end else if (hold > 0) begin
            hold--;
         end
      end
   endtask

   task automatic compare_all();
      logic [W-1:0] e_out;
      int           e_view;
      int           n;
      n      = hist.size();
      e_out  = '0;
      e_view = ridx;
      if (hold != 0) e_view = n - 1;
      if (n != 0) e_out = (hold != 0) ? hist[n - 1] : hist[ridx];
      chk("sample_out",     32'(bus.sample_out),     32'(e_out));
      chk("view_index",     32'(bus.view_index),     32'(e_view));
      chk("count",          32'(bus.count),          32'(n));
      chk("full",           32'(bus.full),           32'(n == D));
      chk("showing_latest", 32'(bus.showing_latest), 32'(hold != 0));
   endtask

   // Apply one cycle of stimulus, update the model at the edge, then compare.
   task automatic step(input bit rst, input bit clr, input bit wr,
                       input bit nx, input bit pv, input logic [W-1:0] din);
      reset               = rst;
      bus.clear           = clr;
      bus.sample_in_valid = wr;
      bus.next_sample     = nx;
      bus.prev_sample     = pv;
      bus.sample_in       = din;
      @(posedge clk);
      model_step(rst, clr, wr, nx, pv, din);
      #1;
      compare_all();
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 8'h00);
   endtask

   task automatic wr(input logic [W-1:0] d);
      step(0, 0, 1, 0, 0, d);
   endtask

   initial begin
      reset               = 1'b1;
      bus.clear           = 1'b0;
      bus.sample_in_valid = 1'b0;
      bus.next_sample     = 1'b0;
      bus.prev_sample     = 1'b0;
      bus.sample_in       = '0;

      step(1, 0, 0, 0, 0, 8'h00);
      step(1, 0, 0, 0, 0, 8'h00);
      chk("rst_out", 32'(bus.sample_out), 32'h00);
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_full", 32'(bus.full), 0);
      chk("rst_showing", 32'(bus.showing_latest), 0);
      step(0, 0, 0, 1, 0, 8'h00);
      chk("empty_next_view", 32'(bus.view_index), 0);
      step(0, 0, 0, 0, 1, 8'h00);
      chk("empty_prev_view", 32'(bus.view_index), 0);

      // Three writes, then let the hold expire.
      wr(8'hA1); wr(8'hA2); wr(8'hA3);
      chk("hold_c1", 32'(bus.showing_latest), 1);
      chk("hold_out", 32'(bus.sample_out), 32'hA3);
      idle(1); chk("hold_c2", 32'(bus.showing_latest), 1);
      idle(1); chk("hold_c3", 32'(bus.showing_latest), 1);
      idle(1); chk("hold_end", 32'(bus.showing_latest), 0);
      chk("view0_out", 32'(bus.sample_out), 32'hA1);
      chk("view0_idx", 32'(bus.view_index), 0);
      chk("count3", 32'(bus.count), 3);

      // Browse forward with a wrap, then back, then both strobes together.
      step(0, 0, 0, 1, 0, 8'h00); chk("next1", 32'(bus.sample_out), 32'hA2);
      step(0, 0, 0, 1, 0, 8'h00); chk("next2", 32'(bus.sample_out), 32'hA3);
      step(0, 0, 0, 1, 0, 8'h00); chk("next_wrap", 32'(bus.sample_out), 32'hA1);
      step(0, 0, 0, 0, 1, 8'h00); chk("prev_wrap", 32'(bus.sample_out), 32'hA3);
      step(0, 0, 0, 1, 1, 8'h00); chk("both_nomove", 32'(bus.sample_out), 32'hA3);

      // Overflow the history.
      step(0, 1, 0, 0, 0, 8'h00);
      for (int i = 1; i <= 5; i++) wr(8'(i));
      chk("ovf_count", 32'(bus.count), 4);
      chk("ovf_full", 32'(bus.full), 1);
      idle(3);
      chk("ovf_view0", 32'(bus.sample_out), 32'h02);
      step(0, 0, 0, 0, 1, 8'h00);
      chk("ovf_view3", 32'(bus.sample_out), 32'h05);
      chk("ovf_idx3", 32'(bus.view_index), 3);
      step(0, 0, 0, 1, 0, 8'h00);
      wr(8'h06); idle(3);
      chk("shift_view0", 32'(bus.sample_out), 32'h03);

      // Navigation right after a write cuts the hold short.
      wr(8'hB7);
      step(0, 0, 0, 1, 0, 8'h00);
      chk("nav_kills_hold", 32'(bus.showing_latest), 0);
      chk("nav_view", 32'(bus.sample_out), 32'h05);

      // Clear during a hold; reset during a write.
      step(0, 1, 0, 0, 0, 8'h00);
      wr(8'hC1); wr(8'hC2); wr(8'hC3);
      step(0, 1, 0, 0, 0, 8'h00);
      chk("clr_count", 32'(bus.count), 0);
      chk("clr_out", 32'(bus.sample_out), 32'h00);
      chk("clr_showing", 32'(bus.showing_latest), 0);
      wr(8'hD1); wr(8'hD2);
      step(1, 0, 1, 0, 0, 8'hD3);
      chk("rstwr_count", 32'(bus.count), 0);
      chk("rstwr_out", 32'(bus.sample_out), 32'h00);
      chk("rstwr_showing", 32'(bus.showing_latest), 0);
      chk("rstwr_view", 32'(bus.view_index), 0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 299) == 0, $urandom_range(0, 59) == 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0, 8'($urandom_range(0, 255)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
